// File: rtl/serial_io_port.sv
// serial_io_port
// Serial I/O peripheral for the computer's 8-bit I/O side.
//   RX: 8N1 frames from rx_in are sampled mid-bit, collected into a small
//       FIFO and handed to INPR through the FGI handshake.
//   TX: bytes from OUTR are taken through the FGO handshake and shifted
//       out on tx_out as 8N1 frames.
// Build option: define SERIAL_IO_PARITY_EN for 8E1 frames (even parity on
// TX, parity check on RX). Without it parity_error_out is tied to 0.
//
// Ports
//   clock             system clock, rising edge
//   reset_in          asynchronous active-high reset
//   rx_in             serial receive line (idle high, asynchronous)
//   tx_out            serial transmit line (idle high)
//   inpr_data_out     byte offered to INPR, held until the next strobe
//   input_load_out    one-cycle strobe: load INPR and set FGI
//   fgi_in            computer FGI flag
//   outr_data_in      computer OUTR contents
//   fgo_in            computer FGO flag
//   output_done_out   one-cycle strobe: set FGO
//   rx_overrun_out    sticky: received byte dropped, FIFO full
//   frame_error_out   sticky: stop bit sampled low
//   parity_error_out  sticky: parity mismatch (parity build only)
//   error_clear_in    synchronous clear of all sticky flags

module serial_io_port #(
  parameter int CLOCKS_PER_BIT = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset_in,
  input  logic       rx_in,
  output logic       tx_out,
  output logic [7:0] inpr_data_out,
  output logic       input_load_out,
  input  logic       fgi_in,
  input  logic [7:0] outr_data_in,
  input  logic       fgo_in,
  output logic       output_done_out,
  output logic       rx_overrun_out,
  output logic       frame_error_out,
  output logic       parity_error_out,
  input  logic       error_clear_in
);

  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [TW-1:0] MID_POINT = TW'(CLOCKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  typedef enum logic {
    IN_IDLE, IN_WAIT_SET
  } in_state_t;

  typedef enum logic [2:0] {
    TX_ARM, TX_WAIT_FGO, TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_DONE
  } tx_state_t;

  logic            rx_meta, rx_sync, rx_prev;
  rx_state_t       rx_state, rx_next;
  logic [TW-1:0]   rx_timer;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_at_sample;
  logic            rx_push;
  logic            frame_evt;
  logic            overrun_evt;
`ifdef SERIAL_IO_PARITY_EN
  logic            rx_par_bad;
  logic            parity_evt;
  logic            tx_parity;
`endif

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            fifo_empty, fifo_full, fifo_write, fifo_pop;

  in_state_t       in_state, in_next;

  tx_state_t       tx_state, tx_next;
  logic [TW-1:0]   tx_timer;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_shift;
  logic            tx_bit_end;
  logic            tx_load;

  // Two-flop synchroniser on the asynchronous receive line, plus a third
  // flop holding the previous synchronised value for falling-edge detection.
  // All three reset high so a reset never looks like a start bit.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // The start bit is checked half a bit after the falling edge; every later
  // sample is a whole bit further on, so each lands mid-bit.
  assign rx_at_sample = (rx_state == RX_START) ? (rx_timer == MID_POINT)
                                               : (rx_timer == BIT_LAST);

  // RX state register.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) rx_state <= RX_IDLE;
    else          rx_state <= rx_next;
  end

  // RX next-state logic. A high start sample is treated as a glitch.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START:  if (rx_at_sample) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (rx_at_sample && rx_bit == 3'd7) begin
`ifdef SERIAL_IO_PARITY_EN
          rx_next = RX_PARITY;
`else
          rx_next = RX_STOP;
`endif
        end
      end
      RX_PARITY: if (rx_at_sample) rx_next = RX_STOP;
      RX_STOP:   if (rx_at_sample) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  // RX outputs: the stop sample decides between pushing the byte and
  // flagging a framing error. A parity failure also withholds the push.
  always_comb begin
    rx_push   = 1'b0;
    frame_evt = 1'b0;
`ifdef SERIAL_IO_PARITY_EN
    parity_evt = 1'b0;
    if (rx_state == RX_PARITY && rx_at_sample)
      parity_evt = (rx_sync != ^rx_shift);
`endif
    if (rx_state == RX_STOP && rx_at_sample) begin
`ifdef SERIAL_IO_PARITY_EN
      rx_push = rx_sync && !rx_par_bad;
`else
      rx_push = rx_sync;
`endif
      frame_evt = !rx_sync;
    end
  end

  // RX datapath: bit timer, bit counter and LSB-first shift register.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      rx_timer <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
`ifdef SERIAL_IO_PARITY_EN
      rx_par_bad <= 1'b0;
`endif
    end else begin
      if (rx_state == RX_IDLE || rx_at_sample) rx_timer <= '0;
      else                                     rx_timer <= rx_timer + TW'(1);

      if (rx_state == RX_IDLE) begin
        rx_bit <= '0;
      end else if (rx_state == RX_DATA && rx_at_sample) begin
        rx_bit   <= rx_bit + 3'd1;
        rx_shift <= {rx_sync, rx_shift[7:1]};
      end
`ifdef SERIAL_IO_PARITY_EN
      if (rx_state == RX_IDLE)
        rx_par_bad <= 1'b0;
      else if (rx_state == RX_PARITY && rx_at_sample)
        rx_par_bad <= parity_evt;
`endif
    end
  end

  // FIFO with one extra pointer bit: equal pointers mean empty, pointers
  // differing only in the top bit mean full. A pop in the same cycle frees
  // the slot, so a push into a full FIFO still succeeds then.
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_write  = rx_push && (!fifo_full || fifo_pop);
  assign overrun_evt = rx_push && fifo_full && !fifo_pop;

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_write) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (fifo_pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (fifo_write) fifo_mem[wr_ptr[AW-1:0]] <= rx_shift;
  end

  // Input handshake state register.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) in_state <= IN_IDLE;
    else          in_state <= in_next;
  end

  // After a strobe, wait for the computer to raise FGI before offering
  // anything else, so a byte is never offered while FGI is still set.
  always_comb begin
    in_next = in_state;
    case (in_state)
      IN_IDLE:     if (!fifo_empty && !fgi_in) in_next = IN_WAIT_SET;
      IN_WAIT_SET: if (fgi_in) in_next = IN_IDLE;
      default:     in_next = IN_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop = (in_state == IN_IDLE) && !fifo_empty && !fgi_in;
  end

  // The strobe and the byte are registered together so INPR sees stable
  // data for the whole strobe cycle.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      input_load_out <= 1'b0;
      inpr_data_out  <= '0;
    end else begin
      input_load_out <= fifo_pop;
      if (fifo_pop) inpr_data_out <= fifo_mem[rd_ptr[AW-1:0]];
    end
  end

  // Sticky error flags; a fresh event outranks a clear in the same cycle.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      rx_overrun_out  <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      rx_overrun_out  <= overrun_evt | (rx_overrun_out & ~error_clear_in);
      frame_error_out <= frame_evt | (frame_error_out & ~error_clear_in);
    end
  end

`ifdef SERIAL_IO_PARITY_EN
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) parity_error_out <= 1'b0;
    else parity_error_out <= parity_evt | (parity_error_out & ~error_clear_in);
  end
`else
  assign parity_error_out = 1'b0;
`endif

  assign tx_bit_end = (tx_timer == BIT_LAST);

  // TX state register. Reset lands in ARM, which also forces tx_out high
  // combinationally the moment reset is asserted.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) tx_state <= TX_ARM;
    else          tx_state <= tx_next;
  end

  // TX next-state logic. FGO must be seen high (computer acknowledged the
  // ready strobe) and then low (computer wrote OUTR) before a byte is sent.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_ARM:      tx_next = TX_WAIT_FGO;
      TX_WAIT_FGO: if (fgo_in) tx_next = TX_IDLE;
      TX_IDLE:     if (!fgo_in) tx_next = TX_START;
      TX_START:    if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA: begin
        if (tx_bit_end && tx_bit == 3'd7) begin
`ifdef SERIAL_IO_PARITY_EN
          tx_next = TX_PARITY;
`else
          tx_next = TX_STOP;
`endif
        end
      end
      TX_PARITY:   if (tx_bit_end) tx_next = TX_STOP;
      TX_STOP:     if (tx_bit_end) tx_next = TX_DONE;
      TX_DONE:     tx_next = TX_WAIT_FGO;
      default:     tx_next = TX_ARM;
    endcase
  end

  // TX outputs: the line level for the current bit and the OUTR latch.
  always_comb begin
    tx_out  = 1'b1;
    tx_load = 1'b0;
    case (tx_state)
      TX_IDLE:   tx_load = !fgo_in;
      TX_START:  tx_out  = 1'b0;
      TX_DATA:   tx_out  = tx_shift[0];
`ifdef SERIAL_IO_PARITY_EN
      TX_PARITY: tx_out  = tx_parity;
`endif
      default:   tx_out  = 1'b1;
    endcase
  end

  // TX datapath. The byte is copied at the latch, so later OUTR changes
  // cannot disturb a frame in progress.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      tx_timer <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
`ifdef SERIAL_IO_PARITY_EN
      tx_parity <= 1'b0;
`endif
    end else begin
      if (tx_state inside {TX_START, TX_DATA, TX_PARITY, TX_STOP} && !tx_bit_end)
        tx_timer <= tx_timer + TW'(1);
      else
        tx_timer <= '0;

      if (tx_load) begin
        tx_shift <= outr_data_in;
        tx_bit   <= '0;
`ifdef SERIAL_IO_PARITY_EN
        tx_parity <= ^outr_data_in;
`endif
      end else if (tx_state == TX_DATA && tx_bit_end) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
    end
  end

  // Done strobe: once for the arming cycle after reset and once per frame,
  // registered so it is clean and low throughout reset.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) output_done_out <= 1'b0;
    else output_done_out <= (tx_state == TX_ARM) || (tx_next == TX_DONE);
  end

endmodule

// File: tb/tb_serial_io_port.sv
// tb_serial_io_port
// Directed bench for serial_io_port at CLOCKS_PER_BIT=8, FIFO_DEPTH=4:
// reset and arming, RX delivery and FGI handshake, FIFO overrun and
// ordering, a TX frame with exact bit timing, framing error with clear,
// and reset asserted in the middle of both directions.

module tb_serial_io_port;

  localparam int CPB = 8;

  logic       clock;
  logic       reset_in;
  logic       rx_in;
  logic       tx_out;
  logic [7:0] inpr_data_out;
  logic       input_load_out;
  logic       fgi_in;
  logic [7:0] outr_data_in;
  logic       fgo_in;
  logic       output_done_out;
  logic       rx_overrun_out;
  logic       frame_error_out;
  logic       parity_error_out;
  logic       error_clear_in;

  int checks = 0;
  int errors = 0;
  logic [7:0] rxLog [$];
  int doneCount = 0;

  serial_io_port #(
    .CLOCKS_PER_BIT(CPB),
    .FIFO_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset_in(reset_in),
    .rx_in(rx_in),
    .tx_out(tx_out),
    .inpr_data_out(inpr_data_out),
    .input_load_out(input_load_out),
    .fgi_in(fgi_in),
    .outr_data_in(outr_data_in),
    .fgo_in(fgo_in),
    .output_done_out(output_done_out),
    .rx_overrun_out(rx_overrun_out),
    .frame_error_out(frame_error_out),
    .parity_error_out(parity_error_out),
    .error_clear_in(error_clear_in)
  );

  // Free-running 100 MHz clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every INPR strobe and every done strobe, sampled mid-cycle.
  always @(negedge clock) begin
    if (input_load_out) rxLog.push_back(inpr_data_out);
    if (output_done_out) doneCount = doneCount + 1;
  end

  // Hard stop in case something wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive one serial frame: start, 8 data bits LSB first, stop bit as given,
  // then return the line to idle.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_in = frame[k];
      repeat (CPB) @(posedge clock);
      #1;
    end
    rx_in = 1'b1;
  endtask

  function automatic logic [7:0] logAt(input int i);
    if (i < rxLog.size()) return rxLog[i];
    return 8'h00;
  endfunction

  initial begin
    int firstDone;
    int pulses;
    int doneAt;
    int startCount;
    int startDone;
    logic txLow;
    logic [9:0] txFrame;
    logic [3:0] partialRx;

    reset_in       = 1'b1;
    rx_in          = 1'b1;
    fgi_in         = 1'b0;
    fgo_in         = 1'b0;
    outr_data_in   = 8'h00;
    error_clear_in = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_tx", tx_out, 1);
    checkOutput("reset_done", output_done_out, 0);
    checkOutput("reset_load", input_load_out, 0);
    checkOutput("reset_inpr", inpr_data_out, 0);
    checkOutput("reset_flags", {rx_overrun_out, frame_error_out, parity_error_out}, 0);

    $display("[TB] arming after reset");
    reset_in  = 1'b0;
    firstDone = -1;
    pulses    = 0;
    txLow     = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (output_done_out) begin
        if (firstDone < 0) firstDone = n;
        pulses++;
      end
      if (!tx_out) txLow = 1'b1;
    end
    checkOutput("arm_done_first_edge", firstDone, 0);
    checkOutput("arm_done_pulses", pulses, 1);
    checkOutput("arm_tx_idle", txLow, 0);

    waitCycles(1);
    fgo_in = 1'b1;
    txLow  = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (!tx_out) txLow = 1'b1;
    end
    checkOutput("tx_idle_fgo_high", txLow, 0);

    $display("[TB] receive 0xA5");
    waitCycles(1);
    applyStimulus(8'hA5, 1'b1);
    waitCycles(10);
    checkOutput("a5_strobes", rxLog.size(), 1);
    checkOutput("a5_data", logAt(0), 8'hA5);
    fgi_in = 1'b1;
    waitCycles(20);
    checkOutput("a5_no_second_strobe", rxLog.size(), 1);
    @(negedge clock);
    checkOutput("a5_inpr_held", inpr_data_out, 8'hA5);

    $display("[TB] overrun and FIFO order");
    waitCycles(1);
    for (int b = 1; b <= 5; b++) applyStimulus(8'(b), 1'b1);
    waitCycles(10);
    checkOutput("overrun_set", rx_overrun_out, 1);
    checkOutput("no_strobe_fgi_high", rxLog.size(), 1);
    for (int i = 0; i < 4; i++) begin
      fgi_in = 1'b0;
      waitCycles(5);
      fgi_in = 1'b1;
      waitCycles(5);
    end
    checkOutput("fifo_strobes", rxLog.size(), 5);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("fifo_byte%0d", i + 1), logAt(i + 1), 32'(i + 1));
    fgi_in = 1'b0;
    waitCycles(10);
    checkOutput("no_fifth_strobe", rxLog.size(), 5);

    $display("[TB] transmit 0x3C");
    txFrame = {1'b1, 8'h3C, 1'b0};
    waitCycles(1);
    outr_data_in = 8'h3C;
    fgo_in       = 1'b0;
    @(posedge clock);
    #1;
    outr_data_in = 8'hFF;
    doneAt = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (n < 80 && (n % 8) == 4)
        checkOutput($sformatf("tx_frame_bit%0d", n / 8), tx_out, txFrame[n / 8]);
      if (output_done_out) begin
        doneAt = n;
        break;
      end
    end
    checkOutput("tx_done_latency", doneAt, 80);
    waitCycles(1);
    fgo_in = 1'b1;
    waitCycles(3);

    $display("[TB] framing error and clear");
    startCount = rxLog.size();
    applyStimulus(8'h7E, 1'b0);
    waitCycles(10);
    checkOutput("frame_error_set", frame_error_out, 1);
    checkOutput("frame_error_no_strobe", rxLog.size(), startCount);
    checkOutput("overrun_sticky", rx_overrun_out, 1);
    error_clear_in = 1'b1;
    waitCycles(1);
    error_clear_in = 1'b0;
    @(negedge clock);
    checkOutput("frame_error_cleared", frame_error_out, 0);
    checkOutput("overrun_cleared", rx_overrun_out, 0);
    checkOutput("parity_error_tied", parity_error_out, 0);

    $display("[TB] reset mid-frame");
    partialRx = 4'b1010;
    waitCycles(1);
    outr_data_in = 8'h00;
    fgo_in       = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rx_in = partialRx[k];
      repeat (CPB) @(posedge clock);
      #1;
    end
    @(negedge clock);
    checkOutput("tx_data_before_reset", tx_out, 0);
    reset_in = 1'b1;
    #1;
    checkOutput("tx_high_in_reset", tx_out, 1);
    checkOutput("load_low_in_reset", input_load_out, 0);
    startCount = rxLog.size();
    startDone  = doneCount;
    repeat (3) @(posedge clock);
    rx_in = 1'b1;
    @(negedge clock);
    reset_in = 1'b0;
    waitCycles(100);
    checkOutput("no_partial_rx_strobe", rxLog.size(), startCount);
    checkOutput("rearm_done_pulse", doneCount - startDone, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_io_port.md
Name: serial_io_port

Overview:
- Serial I/O peripheral attached to the computer's 8-bit I/O side.
- Receives 8N1 UART frames into a small RX FIFO and presents bytes to INPR using the FGI handshake.
- Takes OUTR bytes using the FGO handshake and shifts them out as 8N1 frames.
- Connects the synthesizable computer core to physical serial pins.

Parameters:
- CLOCKS_PER_BIT, 16: clocks per serial bit; must be >= 4. Mid-bit sample point is floor(CLOCKS_PER_BIT/2).
- FIFO_DEPTH, 4: RX FIFO entries; power of two, >= 2.

Ports:
- clock  input  1  system clock, rising edge.
- reset_in  input  1  reset; asynchronous, active-high.
- rx_in  input  1  serial receive line; idles high; asynchronous to clock.
- tx_out  output  1  serial transmit line; idles high.
- inpr_data_out  output  8  byte offered to INPR.
- input_load_out  output  1  one-cycle strobe: load INPR and set FGI.
- fgi_in  input  1  computer FGI flag.
- outr_data_in  input  8  computer OUTR contents.
- fgo_in  input  1  computer FGO flag.
- output_done_out  output  1  one-cycle strobe: set FGO.
- rx_overrun_out  output  1  sticky: byte dropped because the FIFO was full.
- frame_error_out  output  1  sticky: stop bit sampled low.
- parity_error_out  output  1  sticky parity error; tied 0 without the optional feature.
- error_clear_in  input  1  synchronous clear of all sticky flags.

Behaviour:
- Reset (asynchronous, active-high):
  - tx_out=1 immediately; all other outputs 0.
  - FIFO emptied; any partial RX/TX frame is discarded.
  - FSMs return to reset states: RX IDLE, input IDLE, TX ARM.
- RX synchroniser: rx_in passes through two flops; all RX timing uses the synchronised value.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE -> START on a high-to-low transition.
  - START: resample at the mid-bit point. If high, false start -> IDLE. If low -> DATA.
  - DATA: 8 samples, one per CLOCKS_PER_BIT, LSB first.
  - STOP: sample once. High -> push the byte. Low -> set frame_error_out, discard the byte. Both -> IDLE.
  - The stop-bit check replaces the start-bit check in any subsequent frame; back-to-back frames are accepted.
- FIFO rules:
  - Push when full and no pop in the same cycle -> new byte dropped, rx_overrun_out=1.
  - Push and pop in the same cycle when full -> both succeed, no overrun.
  - Pop when empty never occurs.
- Input FSM (IDLE, WAIT_SET):
  - IDLE: if FIFO non-empty and fgi_in==0, drive inpr_data_out=head, pulse input_load_out for one cycle, pop the FIFO, -> WAIT_SET.
  - inpr_data_out holds its value until the next strobe.
  - WAIT_SET -> IDLE when fgi_in==1.
  - No further strobe while fgi_in==1.
- TX FSM (ARM, WAIT_FGO, IDLE, START, DATA, STOP, DONE):
  - ARM: first cycle after reset; pulse output_done_out so FGO reports ready, -> WAIT_FGO.
  - WAIT_FGO -> IDLE once fgo_in==1.
  - IDLE: fgo_in==0 -> latch outr_data_in -> START.
  - START: tx_out=0 for CLOCKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLOCKS_PER_BIT cycles each.
  - STOP: tx_out=1 for CLOCKS_PER_BIT cycles.
  - DONE: pulse output_done_out for one cycle -> WAIT_FGO.
  - Latch to done pulse = 10*CLOCKS_PER_BIT cycles.
  - outr_data_in changes after the latch are ignored.
- Sticky flags: error_clear_in clears them at the next edge. A new error event in the same cycle wins (flag stays 1).
- Counters: bit-timer is ceil(log2(CLOCKS_PER_BIT)) bits wide. FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.

Optional Feature:
- Macro: SERIAL_IO_PARITY_EN.
- Defined:
  - Frames become 8E1: an even-parity bit follows the data on TX, adding CLOCKS_PER_BIT cycles.
  - RX checks the parity bit. On mismatch, parity_error_out=1 and the byte is discarded; a frame error is still checked independently.
- Undefined: 8N1 only; parity_error_out constant 0.

Test Plan:
- CLOCKS_PER_BIT=8. Release reset with fgo_in=0 -> tx_out=1 throughout; output_done_out=1 for exactly one cycle at the first edge after release; no transmission until fgo_in rises then falls.
- fgi_in=0; drive RX frame 0xA5 -> one input_load_out pulse with inpr_data_out=0xA5. Set fgi_in=1 for 20 cycles -> no second strobe; inpr_data_out stays 0xA5.
- fgi_in held 1; send 0x01..0x05 -> rx_overrun_out=1. Then toggle fgi_in low/high four times -> strobes deliver 0x01, 0x02, 0x03, 0x04 in order; no fifth strobe.
- After ready, fgo_in falls with outr_data_in=0x3C -> tx_out is 0, then 0,0,1,1,1,1,0,0, then 1, each bit 8 cycles; output_done_out pulses 80 cycles after the latch.
- Send a frame with the stop bit low, data 0x7E -> frame_error_out=1 and no input_load_out. Pulse error_clear_in -> frame_error_out=0.
- Assert reset_in mid-DATA of a TX byte and mid-DATA of an RX byte -> tx_out=1 in the same cycle; after release, no strobe for the partial RX byte and the TX FSM re-arms (one output_done_out pulse).
